// File: rtl/fpga_main_pkg.sv
// Shared types and constants for the fpga_main "hello" demo: FSM states,
// screen geometry and the active-low seven-segment glyphs.
package fpga_main_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = $clog2(SCREEN_W);
  localparam int Y_W      = $clog2(SCREEN_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Letter glyphs for the "HELLO" banner; dp (bit 7) is always off.
  localparam logic [7:0] GLYPH_H     = 8'h89;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_O     = 8'hC0;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/fpga_main_seg7_hex_decoder.sv
// Combinational nibble -> active-low seven-segment glyph lookup.
// The caller registers the result.
module seg7_hex_decoder
  import fpga_main_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_glyph
);

  assign o_glyph = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/fpga_main.sv
// Board-level "hello" demo: HELLO / switch / draw-counter on the HEX digits,
// switches mirrored on LEDs with a heartbeat on LED[9], and a VGA plotter
// that fills a box on KEY[1] and clears the screen on KEY[2].
// Optional build macro FAKE_FPGA_TEST_PATTERN_EN: box colour becomes
// x[2:0]^y[2:0] per pixel instead of the SW[2:0] value latched at draw start.
module fpga_main
  import fpga_main_pkg::*;
#(
  parameter int BOX_X0 = 40,
  parameter int BOX_Y0 = 30,
  parameter int BOX_W  = 80,
  parameter int BOX_H  = 60,
  parameter int HB_DIV = 25000000
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [9:0]  LED,
  output logic [47:0] HEX,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        vga_resetn
);

  localparam int HB_W = $clog2(HB_DIV);
  localparam logic [X_W-1:0] X_FIRST = X_W'(BOX_X0);
  localparam logic [X_W-1:0] X_LAST  = X_W'(BOX_X0 + BOX_W - 1);
  localparam logic [Y_W-1:0] Y_FIRST = Y_W'(BOX_Y0);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(BOX_Y0 + BOX_H - 1);

  logic w_rst;
  logic w_unused;
  assign w_rst    = KEY[0];
  assign w_unused = KEY[3];

  state_t          r_state, w_state_next;
  logic            r_key1_q, r_key2_q;
  logic            w_draw_rise, w_clr_rise;
  logic [X_W-1:0]  r_px, r_x;
  logic [Y_W-1:0]  r_py, r_y;
  logic [2:0]      r_colour, w_pix_colour;
  logic            r_plot, r_vga_resetn;
  logic [7:0]      r_draw_cnt;
  logic            w_pix_last, w_plot_next, w_vga_resetn_next;
  logic            w_draw_start, w_draw_done;
  logic [8:0]      r_led_sw;
  logic            r_led9;
  logic [HB_W-1:0] r_hb_cnt;
  logic [47:0]     r_hex, w_hex_next;
  logic [7:0]      w_g0, w_g1, w_g2, w_g3;

  assign w_draw_rise = KEY[1] & ~r_key1_q;
  assign w_clr_rise  = KEY[2] & ~r_key2_q;
  assign w_pix_last  = (r_px == X_LAST) && (r_py == Y_LAST);

`ifdef FAKE_FPGA_TEST_PATTERN_EN
  assign w_pix_colour = r_px[2:0] ^ r_py[2:0];
`else
  logic [2:0] r_draw_colour;
  assign w_pix_colour = r_draw_colour;
`endif

  // State register and key edge-detect history.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    if (w_rst) begin
      r_state  <= ST_IDLE;
      r_key1_q <= 1'b0;
      r_key2_q <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_key1_q <= KEY[1];
      r_key2_q <= KEY[2];
    end
  end

  // Next-state and next-output decode; a clear request overrides everything.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    w_state_next      = r_state;
    w_plot_next       = 1'b0;
    w_vga_resetn_next = ~w_clr_rise;
    w_draw_start      = 1'b0;
    w_draw_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_draw_rise) begin
          w_state_next = ST_DRAW;
          w_draw_start = 1'b1;
        end
      end
      ST_DRAW: begin
        w_plot_next = 1'b1;
        if (w_pix_last) begin
          w_state_next = ST_IDLE;
          w_draw_done  = 1'b1;
        end
      end
      ST_CLEAR: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (w_clr_rise) begin
      w_state_next = ST_CLEAR;
      w_plot_next  = 1'b0;
      w_draw_start = 1'b0;
      w_draw_done  = 1'b0;
    end
  end

  // Raster walker and registered pixel port; x/y/colour hold while idle.
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_px         <= '0;
      r_py         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_vga_resetn <= 1'b1;
      r_draw_cnt   <= '0;
`ifndef FAKE_FPGA_TEST_PATTERN_EN
      r_draw_colour <= '0;
`endif
    end else begin
      r_plot       <= w_plot_next;
      r_vga_resetn <= w_vga_resetn_next;
      if (w_draw_start) begin
        r_px <= X_FIRST;
        r_py <= Y_FIRST;
`ifndef FAKE_FPGA_TEST_PATTERN_EN
        r_draw_colour <= SW[2:0];
`endif
      end
      if (w_plot_next) begin
        r_x      <= r_px;
        r_y      <= r_py;
        r_colour <= w_pix_colour;
        if (r_px == X_LAST) begin
          r_px <= X_FIRST;
          r_py <= r_py + Y_W'(1);
        end else begin
          r_px <= r_px + X_W'(1);
        end
      end
      if (w_draw_done) r_draw_cnt <= r_draw_cnt + 8'd1;
    end
  end

  seg7_hex_decoder u_hex0 (.i_nibble(SW[3:0]),          .o_glyph(w_g0));
  seg7_hex_decoder u_hex1 (.i_nibble(SW[7:4]),          .o_glyph(w_g1));
  seg7_hex_decoder u_hex2 (.i_nibble(r_draw_cnt[3:0]),  .o_glyph(w_g2));
  seg7_hex_decoder u_hex3 (.i_nibble(r_draw_cnt[7:4]),  .o_glyph(w_g3));

  // Select HELLO banner or switch/counter hex view.
  always_comb begin
    w_hex_next = {GLYPH_H, GLYPH_E, GLYPH_L, GLYPH_L, GLYPH_O, GLYPH_BLANK};
    if (SW[9]) w_hex_next = {GLYPH_BLANK, GLYPH_BLANK, w_g3, w_g2, w_g1, w_g0};
  end

  // LED mirror, heartbeat divider and HEX output register.
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_led_sw <= '0;
      r_led9   <= 1'b0;
      r_hb_cnt <= '0;
      r_hex    <= {6{GLYPH_BLANK}};
    end else begin
      r_led_sw <= SW[8:0];
      r_hex    <= w_hex_next;
      if (r_hb_cnt == HB_W'(HB_DIV - 1)) begin
        r_hb_cnt <= '0;
        r_led9   <= ~r_led9;
      end else begin
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      end
    end
  end

  assign LED        = {r_led9, r_led_sw};
  assign HEX        = r_hex;
  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign vga_resetn = r_vga_resetn;

endmodule

// File: tb/tb_fpga_main.sv
// Directed bench for fpga_main with a pixel scoreboard: expected pixels are
// queued when a draw is requested and popped as plot cycles appear.
module tb_fpga_main;

  localparam int BX0 = 2;
  localparam int BY0 = 3;
  localparam int BW  = 4;
  localparam int BH  = 2;
  localparam int HBD = 4;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  logic        clk;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic [47:0] hex;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        vga_resetn;

  int   n_checks = 0;
  int   n_errors = 0;
  int   plot_cnt = 0;
  int   rstn_lo_cnt = 0;
  int   exp_cnt = 0;
  pix_t exp_q[$];
  pix_t last_pushed;

  fpga_main #(
    .BOX_X0(BX0), .BOX_Y0(BY0), .BOX_W(BW), .BOX_H(BH), .HB_DIV(HBD)
  ) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LED(led), .HEX(hex),
    .x(x), .y(y), .colour(colour), .plot(plot), .vga_resetn(vga_resetn)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [47:0] exp_hex(input logic [9:0] s, input int cnt);
    logic [7:0] c;
    c = 8'(cnt);
    if (!s[9]) return 48'h8986_C7C7_C0FF;
    return {8'hFF, 8'hFF, hex_glyph(c[7:4]), hex_glyph(c[3:0]),
            hex_glyph(s[7:4]), hex_glyph(s[3:0])};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_box(input logic [2:0] sw_col);
    pix_t p;
    for (int yy = BY0; yy < BY0 + BH; yy++) begin
      for (int xx = BX0; xx < BX0 + BW; xx++) begin
        p.px = 8'(xx);
        p.py = 7'(yy);
`ifdef FAKE_FPGA_TEST_PATTERN_EN
        p.pc = 3'(xx) ^ 3'(yy);
`else
        p.pc = sw_col;
`endif
        exp_q.push_back(p);
        last_pushed = p;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    pix_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!vga_resetn) rstn_lo_cnt++;
      if (plot) begin
        plot_cnt++;
        check("pixel_expected", 48'(exp_q.size() > 0), 48'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel", 48'({x, y, colour}), 48'(e));
        end
      end
    end
  endtask

  task automatic hb_run(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check("led9", 48'(led[9]), 48'((k / HBD) % 2));
    end
  endtask

  task automatic pulse_draw();
    key[1] = 1'b1;
    tick();
    key[1] = 1'b0;
  endtask

  initial begin
    key = 4'b0001;
    sw  = 10'h000;

    // Reset and banner.
    tick();
    check("hex_in_reset", hex, 48'hFFFF_FFFF_FFFF);
    check("vga_resetn_in_reset", 48'(vga_resetn), 48'(1));
    tick();
    key = 4'b0000;
    tick();
    check("led_after_reset", 48'(led), 48'(0));
    check("plot_after_reset", 48'(plot), 48'(0));
    check("vga_resetn_after_reset", 48'(vga_resetn), 48'(1));
    check("xyc_after_reset", 48'({x, y, colour}), 48'(0));
    check("hex_hello", hex, exp_hex(sw, 0));

    // Heartbeat: one check above was edge 1 after reset; continue from 2.
    for (int k = 2; k <= 9; k++) begin
      tick();
      check("led9", 48'(led[9]), 48'((k / HBD) % 2));
    end
    // Reset mid-period restarts the heartbeat.
    key[0] = 1'b1;
    tick();
    check("led9_reset", 48'(led[9]), 48'(0));
    key[0] = 1'b0;
    hb_run(6);

    // Switch view.
    sw = 10'h2A5;
    tick();
    check("hex_sw_a5", hex, 48'hFFFF_C0C0_8892);
    check("led_sw_a5", 48'(led[8:0]), 48'h0A5);
    sw = 10'h23C;
    tick();
    check("hex_sw_3c", hex, exp_hex(sw, exp_cnt));
    check("led_sw_3c", 48'(led[8:0]), 48'h03C);

    // Full draw, colour 5, with a KEY[1] rise mid-draw that must be ignored.
    sw = 10'h005;
    push_box(sw[2:0]);
    pulse_draw();
    check("plot_not_on_request_edge", 48'(plot), 48'(0));
    plot_cnt = 0;
    run_cycles(2);
    key[1] = 1'b1;
    run_cycles(1);
    key[1] = 1'b0;
    run_cycles(11);
    exp_cnt++;
    check("draw_plot_count", 48'(plot_cnt), 48'(BW * BH));
    check("draw_queue_empty", 48'(exp_q.size()), 48'(0));
    check("plot_low_after_draw", 48'(plot), 48'(0));
    check("xyc_hold", 48'({x, y, colour}), 48'(last_pushed));
    sw = 10'h200;
    tick();
    check("hex_count_01", hex, 48'hFFFF_C0F9_C0C0);

    // Clear in the middle of a draw.
    sw = 10'h203;
    push_box(sw[2:0]);
    pulse_draw();
    plot_cnt = 0;
    run_cycles(3);
    check("partial_plot_count", 48'(plot_cnt), 48'(3));
    key[2] = 1'b1;
    tick();
    key[2] = 1'b0;
    check("clear_vga_resetn_low", 48'(vga_resetn), 48'(0));
    check("clear_plot_low", 48'(plot), 48'(0));
    exp_q.delete();
    plot_cnt = 0;
    rstn_lo_cnt = 0;
    run_cycles(12);
    check("clear_one_cycle", 48'(rstn_lo_cnt), 48'(0));
    check("no_plot_after_clear", 48'(plot_cnt), 48'(0));
    check("hex_count_after_abort", hex, exp_hex(sw, exp_cnt));

    // KEY[2] and KEY[1] rise together: clear wins, nothing drawn.
    key[1] = 1'b1;
    key[2] = 1'b1;
    tick();
    key[1] = 1'b0;
    key[2] = 1'b0;
    check("prio_vga_resetn_low", 48'(vga_resetn), 48'(0));
    plot_cnt = 0;
    run_cycles(12);
    check("prio_no_plot", 48'(plot_cnt), 48'(0));
    check("prio_count", hex, exp_hex(sw, exp_cnt));

    // Reset in the middle of a draw.
    sw = 10'h201;
    push_box(sw[2:0]);
    pulse_draw();
    plot_cnt = 0;
    run_cycles(2);
    check("pre_reset_plot_count", 48'(plot_cnt), 48'(2));
    key[0] = 1'b1;
    tick();
    check("reset_mid_draw_plot", 48'(plot), 48'(0));
    check("reset_mid_draw_xyc", 48'({x, y, colour}), 48'(0));
    check("reset_mid_draw_hex", hex, 48'hFFFF_FFFF_FFFF);
    key[0] = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
    plot_cnt = 0;
    run_cycles(12);
    check("no_plot_after_reset", 48'(plot_cnt), 48'(0));
    check("hex_count_reset", hex, exp_hex(sw, exp_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
